// File: rtl/cache_pkg.sv
// Shared cache refill types and constants: line geometry, refill FSM states
// and the address-to-line-tag helper used by the dcache and icache refill paths.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;
  localparam int BEAT_W = 32;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PROBE    = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_DATA = 3'd3,
    RESP     = 3'd4
  } state_e;

  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Builds a cache line from BEAT_W-wide beats in arrival order, or loads a whole
// line at once; done flags the beat that completes the line.
module line_assembler
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic              load_valid,
  input  logic [LINE_W-1:0] load_data,
  output logic [LINE_W-1:0] line,
  output logic              done
);

  logic [CNT_W-1:0]  cnt_r;
  logic [LINE_W-1:0] line_r;

  // Beat counter; wraps naturally after the last beat so the next burst starts at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (start) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (beat_valid) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Line storage carries no reset: its contents are only consumed after being written
  always_ff @(posedge clk) begin
    if (load_valid) begin
      line_r <= load_data;
    end else if (beat_valid) begin
      line_r[BEAT_W*cnt_r +: BEAT_W] <= beat_data;
    end else begin
      line_r <= line_r;
    end
  end

  assign line = line_r;
  assign done = beat_valid && (cnt_r == CNT_W'(BEATS - 1));

endmodule

// File: rtl/dcache_refill_unit.sv
// L1 dcache miss handler: probes victim_cache, falls back to a 16-beat memory
// burst, returns the line and writes the evicted line into victim_cache.
module dcache_refill_unit
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              evict_valid,
  input  logic [TAG_W-1:0]  evict_tag,
  input  logic [LINE_W-1:0] evict_data,
  output logic [TAG_W-1:0]  vc_r_tag,
  input  logic              vc_hit,
  input  logic [LINE_W-1:0] vc_data,
  output logic              vc_we,
  output logic [TAG_W-1:0]  vc_w_tag,
  output logic [LINE_W-1:0] vc_wdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_from_victim
);

  state_e            state_r;
  logic [TAG_W-1:0]  tag_r;
  logic [TAG_W-1:0]  evict_tag_r;
  logic [LINE_W-1:0] evict_data_r;
  logic              evict_pending_r;
  logic              from_victim_r;
  logic              req_ready_r;
  logic              mem_req_r;
  logic              resp_valid_r;
  logic              vc_we_r;

  logic              start_s;
  logic              beat_valid_s;
  logic              load_valid_s;
  logic              done_s;
  logic [LINE_W-1:0] line_s;

  // Gate assembler controls by state so hits and beats outside their phase are ignored
  always_comb begin
    start_s      = 1'b0;
    beat_valid_s = 1'b0;
    load_valid_s = 1'b0;
    case (state_r)
      PROBE:    load_valid_s = vc_hit;
      MEM_REQ:  start_s      = mem_req_ready;
      MEM_DATA: beat_valid_s = mem_rvalid;
      default:  start_s      = 1'b0;
    endcase
  end

  line_assembler u_line_assembler (
    .clk        (clk),
    .rst        (rstn),
    .start      (start_s),
    .beat_valid (beat_valid_s),
    .beat_data  (mem_rdata),
    .load_valid (load_valid_s),
    .load_data  (vc_data),
    .line       (line_s),
    .done       (done_s)
  );

  // Refill FSM with registered handshake outputs; the evict write fires on RESP entry
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_r         <= IDLE;
      req_ready_r     <= 1'b1;
      mem_req_r       <= 1'b0;
      resp_valid_r    <= 1'b0;
      vc_we_r         <= 1'b0;
      evict_pending_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            tag_r       <= line_tag(req_addr);
            req_ready_r <= 1'b0;
            state_r     <= PROBE;
            if (evict_valid) begin
              evict_tag_r     <= evict_tag;
              evict_data_r    <= evict_data;
              evict_pending_r <= 1'b1;
            end else begin
              evict_pending_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        PROBE: begin
          if (vc_hit) begin
            from_victim_r   <= 1'b1;
            resp_valid_r    <= 1'b1;
            vc_we_r         <= evict_pending_r;
            evict_pending_r <= 1'b0;
            state_r         <= RESP;
          end else begin
            mem_req_r <= 1'b1;
            state_r   <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_r <= 1'b0;
            state_r   <= MEM_DATA;
          end else begin
            state_r <= MEM_REQ;
          end
        end
        MEM_DATA: begin
          if (done_s) begin
            from_victim_r   <= 1'b0;
            resp_valid_r    <= 1'b1;
            vc_we_r         <= evict_pending_r;
            evict_pending_r <= 1'b0;
            state_r         <= RESP;
          end else begin
            state_r <= MEM_DATA;
          end
        end
        RESP: begin
          vc_we_r <= 1'b0;
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          mem_req_r    <= 1'b0;
          resp_valid_r <= 1'b0;
          vc_we_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_r;
  assign vc_r_tag         = tag_r;
  assign vc_we            = vc_we_r;
  assign vc_w_tag         = evict_tag_r;
  assign vc_wdata         = evict_data_r;
  assign mem_req          = mem_req_r;
  assign mem_addr         = {tag_r, {OFF_W{1'b0}}};
  assign resp_valid       = resp_valid_r;
  assign resp_data        = line_s;
  assign resp_from_victim = from_victim_r;

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed + randomized bench for dcache_refill_unit; expected lines, tags and
// latencies come from a transaction-level model of the refill rules.
module tb_dcache_refill_unit;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         evict_valid;
  logic [25:0]  evict_tag;
  logic [511:0] evict_data;
  logic [25:0]  vc_r_tag;
  logic         vc_hit;
  logic [511:0] vc_data;
  logic         vc_we;
  logic [25:0]  vc_w_tag;
  logic [511:0] vc_wdata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_req_ready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [511:0] resp_data;
  logic         resp_from_victim;

  int checks = 0;
  int errors = 0;
  int vc_we_cnt = 0;
  logic        vc_force_hit;
  logic [25:0] vc_hit_tag;

  dcache_refill_unit dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_data(evict_data),
    .vc_r_tag(vc_r_tag), .vc_hit(vc_hit), .vc_data(vc_data),
    .vc_we(vc_we), .vc_w_tag(vc_w_tag), .vc_wdata(vc_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_req_ready(mem_req_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_from_victim(resp_from_victim)
  );

  always #5 clk = ~clk;

  // victim_cache only hits when probed with the tag of the current miss
  assign vc_hit = vc_force_hit && (vc_r_tag == vc_hit_tag);

  always @(posedge clk) if (vc_we) vc_we_cnt <= vc_we_cnt + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete miss transaction from accept to response handshake
  task automatic txn(input logic [31:0] addr, input bit hit, input bit ev, input logic [25:0] etag,
                     input int req_wait, input int gap, input int resp_wait, input bit stray,
                     input bit seq_beats);
    logic [511:0] vline, eline, exp_line;
    logic [25:0]  exp_tag;
    logic [31:0]  beats [16];
    int cyc, nb, rc, gc, we0, exp_lat;
    bit streaming, hs, got_req;
    vline = rand_line();
    eline = rand_line();
    for (int i = 0; i < 16; i++) beats[i] = seq_beats ? 32'(i) : $urandom;
    exp_tag = addr[31:6];
    exp_line = vline;
    if (!hit) for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = beats[i];
    exp_lat = hit ? 2 : 4 + req_wait + 15 * (gap + 1);

    chk("req_ready_idle", req_ready, 1'b1);
    we0 = vc_we_cnt;
    req_valid = 1'b1; req_addr = addr;
    evict_valid = ev; evict_tag = etag; evict_data = eline;
    vc_force_hit = hit; vc_hit_tag = exp_tag; vc_data = vline;
    tick();
    cyc = 1;
    req_valid = 1'b0; evict_valid = 1'b0;
    evict_tag = ~etag; evict_data = ~eline; req_addr = $urandom;
    chk("req_ready_busy", req_ready, 1'b0);

    streaming = 1'b0; nb = 0; rc = 0; gc = 0; got_req = 1'b0;
    while (!resp_valid && cyc < 400) begin
      hs = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        chk("mem_addr", mem_addr, {exp_tag, 6'b0});
        got_req = 1'b1;
        mem_req_ready = (rc >= req_wait);
        hs = mem_req_ready;
        rc++;
      end else if (streaming) begin
        if (nb < 16) begin
          if (gc == 0) begin
            mem_rvalid = 1'b1; mem_rdata = beats[nb]; nb++; gc = gap;
          end else begin
            gc--;
          end
        end
      end else if (stray && cyc == 1) begin
        mem_rvalid = 1'b1;
      end
      tick();
      cyc++;
      if (hs) streaming = 1'b1;
      if (cyc == 2) vc_data = ~vline;
    end
    mem_rvalid = 1'b0; mem_req_ready = 1'b0;

    chk("resp_valid", resp_valid, 1'b1);
    chk("latency", cyc, exp_lat);
    chk("mem_req_seen", got_req, !hit);
    chk("beats_used", nb, hit ? 0 : 16);
    chk("resp_data", resp_data, exp_line);
    chk("from_victim", resp_from_victim, hit);
    chk("vc_we_first", vc_we, ev);
    if (ev) begin
      chk("vc_w_tag", vc_w_tag, etag);
      chk("vc_wdata", vc_wdata, eline);
    end
    for (int i = 0; i < resp_wait; i++) begin
      tick();
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_data", resp_data, exp_line);
      chk("hold_vc_we", vc_we, 1'b0);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    vc_force_hit = 1'b0;
    chk("post_valid", resp_valid, 1'b0);
    chk("post_req_ready", req_ready, 1'b1);
    chk("vc_we_pulses", vc_we_cnt - we0, ev ? 1 : 0);
  endtask

  initial begin
    rstn = 1'b1; req_valid = 1'b0; req_addr = 32'h0; evict_valid = 1'b0;
    evict_tag = 26'h0; evict_data = 512'h0; vc_data = 512'h0;
    vc_force_hit = 1'b0; vc_hit_tag = 26'h0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_vc_we", vc_we, 1'b0);

    // Reset in the middle of a burst with seven beats already taken
    req_valid = 1'b1; req_addr = 32'h0000_2000;
    tick();
    req_valid = 1'b0;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000 + 32'(i);
      tick();
    end
    mem_rvalid = 1'b0;
    rstn = 1'b1;
    repeat (3) tick();
    rstn = 1'b0;
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_mem_req", mem_req, 1'b0);
    tick();
    chk("midrst_req_ready2", req_ready, 1'b1);
    chk("midrst_mem_req2", mem_req, 1'b0);

    txn(32'h1234_5678, 1'b1, 1'b0, 26'h0, 0, 0, 0, 1'b0, 1'b0);
    txn(32'h0000_1040, 1'b0, 1'b0, 26'h0, 0, 0, 0, 1'b0, 1'b1);
    txn($urandom, 1'b0, 1'b1, 26'h2ABCDEF, 4, 2, 5, 1'b0, 1'b0);
    txn($urandom, 1'b1, 1'b1, 26'($urandom), 0, 0, 0, 1'b0, 1'b0);
    txn($urandom, 1'b0, 1'b0, 26'($urandom), 0, 0, 1, 1'b1, 1'b0);

    for (int n = 0; n < 10; n++) begin
      txn($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 26'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_refill_unit.md
Name: dcache_refill_unit

Overview:
- Miss-handling stage of the L1 dcache, directly upstream of victim_cache.
- Accepts one line miss at a time and probes victim_cache with the 26-bit line tag (20-bit tag + 6-bit index).
- On a victim hit, returns that 512-bit line. On a victim miss, fetches the line from memory as a 16-beat 32-bit burst and assembles it.
- Writes the line evicted by the same miss into victim_cache, completing the L1/victim swap.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, cache line width in bits
BEAT_W, 32, memory data beat width
BEATS, LINE_W/BEAT_W = 16, beats per line
TAG_W, 26, line tag width = ADDR_W - log2(LINE_W/8)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous reset, active-high (1 = reset) despite the name
req_valid  in  1  miss request
req_ready  out  1  unit can accept a request (IDLE only)
req_addr  in  ADDR_W  miss address; bits [5:0] ignored
evict_valid  in  1  request carries an evicted line (sampled with req)
evict_tag  in  TAG_W  evicted line tag
evict_data  in  LINE_W  evicted line data
vc_r_tag  out  TAG_W  victim_cache lookup tag
vc_hit  in  1  victim_cache hit (combinational from vc_r_tag)
vc_data  in  LINE_W  victim_cache hit data
vc_we  out  1  victim_cache write strobe
vc_w_tag  out  TAG_W  victim_cache write tag
vc_wdata  out  LINE_W  victim_cache write data
mem_req  out  1  burst read request
mem_addr  out  ADDR_W  line-aligned burst address
mem_req_ready  in  1  memory accepts burst request
mem_rvalid  in  1  read beat valid; no backpressure from this unit
mem_rdata  in  BEAT_W  read beat data
resp_valid  out  1  refill line ready
resp_ready  in  1  dcache consumes line
resp_data  out  LINE_W  refill line
resp_from_victim  out  1  line came from victim_cache

Behaviour:
- Reset: state IDLE. req_ready=1. resp_valid, vc_we and mem_req are 0. Beat counter and the evict-pending flag are 0. Data registers are don't-care.
- Reset mid-operation returns to IDLE immediately. The outstanding burst is dropped; memory shares this reset, so no stale beats arrive.
- IDLE: req_ready=1.
  - On req_valid, latch tag = req_addr[31:6].
  - If evict_valid, also latch evict_tag and evict_data and set the evict-pending flag.
  - Go to PROBE.
- PROBE (1 cycle): vc_r_tag = latched tag.
  - vc_hit=1: capture vc_data into the line register, set from_victim=1, go to RESP.
  - vc_hit=0: go to MEM_REQ.
- MEM_REQ: mem_req=1 and mem_addr = {tag, 6'b0}, both held stable until mem_req_ready. On the handshake cycle, go to MEM_DATA with beat counter=0.
- MEM_DATA:
  - Each mem_rvalid writes mem_rdata into line[BEAT_W*cnt +: BEAT_W], then cnt increments.
  - The beat with cnt=BEATS-1 moves to RESP; the counter wraps to 0.
  - Set from_victim=0.
- RESP: resp_valid=1 with resp_data and resp_from_victim stable until resp_ready.
  - If evict-pending is set, vc_we=1 for exactly the first RESP cycle, with vc_w_tag=evict_tag and vc_wdata=evict_data; then clear the flag.
  - The write happens after PROBE, so a victim hit line is read before any replacement slot is overwritten.
  - On resp_ready, go to IDLE. Earliest new accept is the next cycle.
- Latency, victim hit: accept at cycle 0, resp_valid at cycle 2.
- Latency, memory with zero-wait request and back-to-back beats: resp_valid at cycle 2 + 1 + 16 = 19.
- vc_r_tag is driven only in PROBE; it holds the latched tag otherwise (no glitch requirement).
- mem_rvalid outside MEM_DATA is ignored.
- Stale victim entries: duplicate tags left after a swap are resolved inside victim_cache (write with a matching tag overwrites that entry). That is out of scope here.

Decomposition:
- Shared package cache_pkg holds LINE_W, BEAT_W, BEATS, TAG_W, the state enum {IDLE, PROBE, MEM_REQ, MEM_DATA, RESP} and the tag-extract helper.
- One sub-module: line_assembler (beat counter + LINE_W shift/insert register with done pulse), reusable by the icache refill path.

Test Plan:
- Reset held 3 cycles mid-MEM_DATA (cnt=7) -> next cycle IDLE, req_ready=1, resp_valid=0, mem_req=0.
- req_addr=0x1234_5678, evict_valid=0, vc_hit=1, vc_data=pattern A -> resp_valid at cycle 2, resp_data=A, resp_from_victim=1, no mem_req, vc_we never 1.
- req_addr=0x0000_1040, vc_hit=0, beats 0x0..0xF -> mem_addr=0x0000_1040, resp_data[31:0]=0x0, resp_data[511:480]=0xF, resp_from_victim=0, resp_valid at cycle 19.
- Victim miss with evict_valid=1, evict_tag=0x2ABCDEF, data B, mem beats gapped (rvalid every 3rd cycle) and mem_req_ready delayed 4 cycles -> mem_addr stable throughout, exactly one vc_we pulse on the first RESP cycle with tag 0x2ABCDEF and data B.
- resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable, vc_we still a single pulse, req_ready=0 until the cycle after resp_ready.
- Two back-to-back requests (hit, then miss) -> second accepted the cycle after the first resp handshake; stray mem_rvalid during PROBE ignored, beat count unaffected.
